ram_rom_mem: RTL and testbench
==============================

Name: ram_rom_mem

Overview:
- Parametrised single-clock memory; successor to the fixed 4x4 combinational lookup table.
- After every reset, the block preloads itself with the default ROM pattern.
- Afterwards it acts as a synchronous RAM with one write port and one registered read port.
- A lock input makes it behave as a ROM (writes rejected). Sits between datapath/control logic and any consumer of table constants.

Parameters:
ADDR_WIDTH, 2, address width; DEPTH = 2**ADDR_WIDTH entries
DATA_WIDTH, 4, word width; must be >= 4

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
init_req  input  1  pulse in READY: re-run preload sweep
rom_lock  input  1  1 = writes rejected (ROM mode)
wr_en  input  1  write request
wr_addr  input  ADDR_WIDTH  write address
wr_data  input  DATA_WIDTH  write data
rd_en  input  1  read request
rd_addr  input  ADDR_WIDTH  read address
rd_data  output  DATA_WIDTH  registered read data
rd_valid  output  1  one-cycle pulse, rd_data valid
ready  output  1  1 = preload done, accepting requests
wr_err  output  1  one-cycle pulse, write rejected

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values (while rst_n=0): rd_data=0, rd_valid=0, ready=0, wr_err=0, FSM=INIT, sweep counter=0. Array contents are not reset directly; they are rewritten by the sweep.
- Default pattern: entry i = zero-extended value of table[i mod 4], where table = {0100, 1100, 0110, 0111} (index 0..3).
- FSM, two states:
  - INIT: each cycle writes the default pattern to address cnt, then cnt++. When cnt = DEPTH-1 is written, the next state is READY.
  - READY: normal operation. init_req=1 -> INIT with cnt=0.
- Preload latency: ready rises exactly DEPTH rising edges after rst_n deasserts (4 with defaults). ready=0 for the whole of INIT.
- During INIT:
  - wr_en, rd_en and rom_lock are ignored.
  - rd_valid=0 and wr_err=0.
  - rd_data holds its last value.
- Write (READY):
  - wr_en=1, rom_lock=0: mem[wr_addr] <= wr_data at the clock edge.
  - wr_en=1, rom_lock=1: no write; wr_err=1 for exactly the next cycle.
- Read (READY): rd_en=1 -> rd_data <= mem[rd_addr] and rd_valid=1, both on the next cycle. rd_valid is 0 in cycles without an accepted read. Back-to-back reads give one result per cycle.
- Same-cycle read and write to the same address: see Optional Feature.
- Same-cycle init_req and wr_en/rd_en in READY: init_req wins; the request is dropped (no rd_valid, no write, no wr_err).
- Reset asserted mid-sweep or mid-operation: outputs return to reset values immediately (asynchronous). The sweep restarts from address 0 after release.
- Addresses wrap naturally within ADDR_WIDTH; there is no out-of-range case.

Optional Feature:
- Macro: RAM_ROM_BYPASS_EN.
- Defined (write-first): on a same-address read and accepted write in one cycle, rd_data returns wr_data.
- Undefined (read-first): rd_data returns the old contents.
- A write rejected by rom_lock is never forwarded; the read returns the stored value in both builds.

Test Plan:
1. Release rst_n, hold rd_en=0 -> ready=0 for 4 edges, ready=1 after the 4th. Then read addrs 0..3 back-to-back -> rd_data 4'h4, 4'hC, 4'h6, 4'h7 on consecutive cycles, rd_valid=1 each cycle.
2. rom_lock=0, write addr 2 <= 4'hA, then read addr 2 -> rd_data=4'hA with rd_valid pulse one cycle after rd_en.
3. rom_lock=1, write addr 1 <= 4'hF -> wr_err=1 for one cycle. Read addr 1 -> 4'hC.
4. After test 2, pulse init_req -> ready=0 for 4 cycles, then read addr 2 -> 4'h6 (restored).
5. Assert rst_n=0 two cycles into INIT, release -> ready rises exactly 4 edges after release; all four entries match the default pattern.
6. In READY, write addr 3 <= 4'h9 and read addr 3 in the same cycle -> rd_data=4'h7 without RAM_ROM_BYPASS_EN, 4'h9 with it. A subsequent read returns 4'h9 in both builds.

Source files
------------

// File: rtl/ram_rom_mem.sv
// Parametrised single-clock table memory: preloads a default ROM pattern after reset
// or init_req, then serves one write port and one registered read port.
// Build option: define RAM_ROM_BYPASS_EN for write-first same-address read; default is read-first.
module ram_rom_mem #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_req,
  input  logic                  rom_lock,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  ready,
  output logic                  wr_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                  state_r;
  state_t                  state_next_s;
  logic [ADDR_WIDTH-1:0]   cnt_r;
  logic [ADDR_WIDTH-1:0]   cnt_next_s;
  logic [DATA_WIDTH-1:0]   mem_r [DEPTH];

  logic                    mem_we_s;
  logic [ADDR_WIDTH-1:0]   mem_waddr_s;
  logic [DATA_WIDTH-1:0]   mem_wdata_s;
  logic                    wr_acc_s;
  logic                    wr_rej_s;
  logic                    rd_acc_s;
  logic [DATA_WIDTH-1:0]   rd_word_s;

  logic [DATA_WIDTH-1:0]   rd_data_r;
  logic                    rd_valid_r;
  logic                    ready_r;
  logic                    wr_err_r;

  // Default pattern repeats every four entries, zero-extended to the word width.
  function automatic logic [DATA_WIDTH-1:0] default_word(input logic [ADDR_WIDTH-1:0] idx);
    logic [1:0] sel;
    sel = 2'(idx);
    case (sel)
      2'd0:    default_word = DATA_WIDTH'(4'b0100);
      2'd1:    default_word = DATA_WIDTH'(4'b1100);
      2'd2:    default_word = DATA_WIDTH'(4'b0110);
      2'd3:    default_word = DATA_WIDTH'(4'b0111);
      default: default_word = DATA_WIDTH'(4'b0000);
    endcase
  endfunction

  // Next-state, sweep counter and request acceptance; init_req in READY drops any same-cycle request.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    mem_we_s     = 1'b0;
    mem_waddr_s  = wr_addr;
    mem_wdata_s  = wr_data;
    wr_acc_s     = 1'b0;
    wr_rej_s     = 1'b0;
    rd_acc_s     = 1'b0;
    case (state_r)
      INIT: begin
        mem_we_s    = 1'b1;
        mem_waddr_s = cnt_r;
        mem_wdata_s = default_word(cnt_r);
        if (cnt_r == LAST_ADDR) begin
          state_next_s = READY;
          cnt_next_s   = '0;
        end else begin
          cnt_next_s = cnt_r + ADDR_WIDTH'(1);
        end
      end
      READY: begin
        if (init_req) begin
          state_next_s = INIT;
          cnt_next_s   = '0;
        end else begin
          wr_acc_s = wr_en & ~rom_lock;
          wr_rej_s = wr_en & rom_lock;
          rd_acc_s = rd_en;
          mem_we_s = wr_en & ~rom_lock;
        end
      end
      default: begin
        state_next_s = INIT;
        cnt_next_s   = '0;
      end
    endcase
  end

  // Read word selection; only an accepted write is ever forwarded.
  always_comb begin
    rd_word_s = mem_r[rd_addr];
`ifdef RAM_ROM_BYPASS_EN
    if (wr_acc_s && (wr_addr == rd_addr)) begin
      rd_word_s = wr_data;
    end else begin
      rd_word_s = mem_r[rd_addr];
    end
`endif
  end

  // Storage array; contents are rebuilt by the sweep rather than reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= INIT;
      cnt_r      <= '0;
      rd_data_r  <= '0;
      rd_valid_r <= 1'b0;
      ready_r    <= 1'b0;
      wr_err_r   <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      cnt_r      <= cnt_next_s;
      rd_valid_r <= rd_acc_s;
      ready_r    <= (state_next_s == READY);
      wr_err_r   <= wr_rej_s;
      if (rd_acc_s) begin
        rd_data_r <= rd_word_s;
      end
    end
  end

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign ready    = ready_r;
  assign wr_err   = wr_err_r;

endmodule

// File: tb/tb_ram_rom_mem.sv
// Self-checking bench for ram_rom_mem: read results go through a scoreboard queue
// filled when a read is driven and drained when rd_valid is observed.
module tb_ram_rom_mem;

  logic       clk;
  logic       rst_n;
  logic       init_req;
  logic       rom_lock;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic       rd_en;
  logic [1:0] rd_addr;
  logic [3:0] rd_data;
  logic       rd_valid;
  logic       ready;
  logic       wr_err;

  int         n_checks;
  int         n_fails;
  logic [3:0] sb_q[$];
  logic [3:0] bypass_exp;

  ram_rom_mem #(.ADDR_WIDTH(2), .DATA_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .rom_lock(rom_lock),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .ready(ready), .wr_err(wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, push the expected read result, then check outputs after the edge.
  task automatic op(input logic we, input logic [1:0] wa, input logic [3:0] wd,
                    input logic re, input logic [1:0] ra, input logic [3:0] rexp,
                    input logic lock, input logic ireq,
                    input logic exp_rv, input logic exp_ready, input logic exp_err);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr = ra; rom_lock = lock; init_req = ireq;
    if (exp_rv) sb_q.push_back(rexp);
    @(posedge clk);
    #1;
    check_eq("rd_valid", 32'(rd_valid), 32'(exp_rv));
    if (rd_valid) begin
      if (sb_q.size() == 0) check_eq("rd_spurious", 32'(1), 32'(0));
      else check_eq("rd_data", 32'(rd_data), 32'(sb_q.pop_front()));
    end
    check_eq("ready", 32'(ready), 32'(exp_ready));
    check_eq("wr_err", 32'(wr_err), 32'(exp_err));
  endtask

  task automatic idle(input logic exp_ready);
    op(1'b0, 2'd0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0, exp_ready, 1'b0);
  endtask

  task automatic rd(input logic [1:0] a, input logic [3:0] exp);
    op(1'b0, 2'd0, 4'h0, 1'b1, a, exp, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] d, input logic lock);
    op(1'b1, a, d, 1'b0, 2'd0, 4'h0, lock, 1'b0, 1'b0, 1'b1, lock);
  endtask

  task automatic sweep_rest(input int n);
    for (int i = 0; i < n; i++) idle(i == n - 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fails = 0;
    rst_n = 1'b0; init_req = 1'b0; rom_lock = 1'b0;
    wr_en = 1'b0; wr_addr = 2'd0; wr_data = 4'h0;
    rd_en = 1'b0; rd_addr = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_rd_data", 32'(rd_data), 32'(0));
    check_eq("rst_rd_valid", 32'(rd_valid), 32'(0));
    check_eq("rst_ready", 32'(ready), 32'(0));
    check_eq("rst_wr_err", 32'(wr_err), 32'(0));
    rst_n = 1'b1;

    // Preload; requests during INIT are ignored (locked write must not flag, read must not answer).
    op(1'b1, 2'd0, 4'hF, 1'b1, 2'd0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    op(1'b1, 2'd1, 4'hF, 1'b1, 2'd1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    sweep_rest(2);

    // Test 1: back-to-back readback of the default pattern.
    rd(2'd0, 4'h4); rd(2'd1, 4'hC); rd(2'd2, 4'h6); rd(2'd3, 4'h7);
    idle(1'b1);

    // Test 2: unlocked write then read.
    wr(2'd2, 4'hA, 1'b0);
    rd(2'd2, 4'hA);

    // Test 3: locked write rejected with a single-cycle wr_err.
    wr(2'd1, 4'hF, 1'b1);
    idle(1'b1);
    rd(2'd1, 4'hC);

    // Test 4: init_req wins over same-cycle requests and restores the pattern.
    op(1'b1, 2'd0, 4'hF, 1'b1, 2'd2, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    sweep_rest(4);
    rd(2'd2, 4'h6);
    rd(2'd0, 4'h4);

    // Test 5: reset two cycles into a sweep; outputs clear at once, sweep restarts.
    wr(2'd3, 4'hD, 1'b0);
    op(1'b0, 2'd0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b0); idle(1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_rd_data", 32'(rd_data), 32'(0));
    check_eq("midrst_ready", 32'(ready), 32'(0));
    check_eq("midrst_rd_valid", 32'(rd_valid), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sweep_rest(4);
    rd(2'd0, 4'h4); rd(2'd1, 4'hC); rd(2'd2, 4'h6); rd(2'd3, 4'h7);

    // Test 6: same-address read during write; locked writes are never forwarded.
`ifdef RAM_ROM_BYPASS_EN
    bypass_exp = 4'h9;
`else
    bypass_exp = 4'h7;
`endif
    op(1'b1, 2'd3, 4'h9, 1'b1, 2'd3, bypass_exp, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    rd(2'd3, 4'h9);
    op(1'b1, 2'd2, 4'hF, 1'b1, 2'd2, 4'h6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    rd(2'd2, 4'h6);
    idle(1'b1);

    check_eq("sb_empty", 32'(sb_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
